// File: rtl/calc_sequencer_if.sv
// Board-facing signal bundle for the calculator sequencer: switch and key
// inputs plus the registered result and status outputs for the HEX decoders.
interface calc_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [9:0]         SW;
  logic [3:0]         KEY;
  logic [2*WIDTH-1:0] result;
  logic [1:0]         op;
  logic               busy;
  logic               valid;
  logic               neg;
  logic               err;

  modport master (
    output SW, KEY,
    input  result, op, busy, valid, neg, err
  );

  modport slave (
    input  SW, KEY,
    output result, op, busy, valid, neg, err
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator sequencer: synchronizes and debounces the four KEY buttons,
// turns presses into prioritized operation requests, then runs ADD/SUB in
// one cycle and MUL/DIV iteratively (one partial product / quotient bit per
// cycle) before holding a registered result with status flags.
module calc_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  calc_sequencer_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // Input path. The synchronizer holds raw KEY levels (1 = released) and
  // clears to 0, so after reset the keys look pressed until real released
  // levels arrive; this keeps arm low for a key held through reset.
  logic [3:0]    keyMeta_q, keySync_q;
  logic [3:0]    deb_q, debPrev_q;
  logic [DW-1:0] debCnt_q [4];
  logic          arm_q;

  // Sequencer and datapath registers
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quot_q, quot_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d, valid_q, valid_d, neg_q, neg_d, err_q, err_d;

  logic [3:0]         pressEvt;
  logic               evValid;
  logic [1:0]         evOp;
  logic               lastStep;
  logic [2*WIDTH-1:0] mulAddend, mulSum;
  logic [CW-1:0]      divIdx;
  logic [WIDTH:0]     divShift, divDiff;
  logic               divBit;
  logic [WIDTH-1:0]   divRemNext, divQuotNext;
  logic               swUnused;

  assign swUnused = ^bus.SW[9:8];

  // Synchronize, debounce and arm the key inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      keyMeta_q <= '0;
      keySync_q <= '0;
      deb_q     <= '0;
      debPrev_q <= '0;
      arm_q     <= 1'b0;
      for (int i = 0; i < 4; i++) debCnt_q[i] <= '0;
    end else begin
      keyMeta_q <= bus.KEY;
      keySync_q <= keyMeta_q;
      debPrev_q <= deb_q;
      if (deb_q == 4'b0000 && keySync_q == 4'b1111) arm_q <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (~keySync_q[i] != deb_q[i]) begin
          if (debCnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_q[i]    <= ~keySync_q[i];
            debCnt_q[i] <= '0;
          end else begin
            debCnt_q[i] <= debCnt_q[i] + 1'b1;
          end
        end else begin
          debCnt_q[i] <= '0;
        end
      end
    end
  end

  assign pressEvt = deb_q & ~debPrev_q & {4{arm_q}};
  assign evValid  = |pressEvt;
  assign evOp     = pressEvt[0] ? OP_ADD :
                    pressEvt[1] ? OP_SUB :
                    pressEvt[2] ? OP_MUL : OP_DIV;

  // State and datapath register; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept a request when not executing, step the
  // iterative ops, and register the result on the final EXEC cycle
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    result_d    = result_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    neg_d       = neg_q;
    err_d       = err_q;
    lastStep    = (cnt_q == CW'(WIDTH - 1));
    mulAddend   = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    mulSum      = acc_q + mulAddend;
    divIdx      = CW'(WIDTH - 1) - cnt_q;
    divShift    = {rem_q, a_q[divIdx]};
    divBit      = (divShift >= {1'b0, b_q});
    divDiff     = divShift - {1'b0, b_q};
    divRemNext  = divBit ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
    divQuotNext = {quot_q[WIDTH-2:0], divBit};

    case (state_q)
      IDLE, DONE: begin
        if (evValid) begin
          a_d     = bus.SW[WIDTH-1:0];
          b_d     = bus.SW[2*WIDTH-1:WIDTH];
          op_d    = evOp;
          cnt_d   = '0;
          acc_d   = '0;
          rem_d   = '0;
          quot_d  = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_ADD: begin
            result_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
            neg_d    = 1'b0;
            err_d    = 1'b0;
            state_d  = DONE;
          end
          OP_SUB: begin
            result_d = (a_q < b_q) ? {{WIDTH{1'b0}}, b_q - a_q}
                                   : {{WIDTH{1'b0}}, a_q - b_q};
            neg_d    = (a_q < b_q);
            err_d    = 1'b0;
            state_d  = DONE;
          end
          OP_MUL: begin
            acc_d = mulSum;
            cnt_d = cnt_q + 1'b1;
            if (lastStep) begin
              result_d = mulSum;
              neg_d    = 1'b0;
              err_d    = 1'b0;
              state_d  = DONE;
            end
          end
          default: begin
            if (b_q == '0) begin
              result_d = '0;
              neg_d    = 1'b0;
              err_d    = 1'b1;
              state_d  = DONE;
            end else begin
              rem_d  = divRemNext;
              quot_d = divQuotNext;
              cnt_d  = cnt_q + 1'b1;
              if (lastStep) begin
                result_d = {divRemNext, divQuotNext};
                neg_d    = 1'b0;
                err_d    = 1'b0;
                state_d  = DONE;
              end
            end
          end
        endcase
        if (state_d == DONE) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result = result_q;
  assign bus.op     = op_q;
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed key scenarios plus
// randomized operations, compared against a plain-arithmetic model of the
// calculator and of the busy/latency behaviour.
module tb_calc_sequencer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   busyCycles, starts;
  logic [3:0] keySeq [$];

  logic [7:0] mResult;
  logic [1:0] mOp;
  logic       mValid, mNeg, mErr;

  always #5 clk = ~clk;

  calc_sequencer_if #(.WIDTH(W)) bus ();

  calc_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Global time limit so the run always terminates
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pushKeys(input logic [3:0] pressedMask, input int n);
    for (int i = 0; i < n; i++) keySeq.push_back(~pressedMask);
  endtask

  // Plays the queued KEY pattern (released afterwards) with fixed operands,
  // counting busy cycles and operation starts seen at each sample point
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input int window);
    logic prevBusy;
    bus.SW     = {2'($urandom), b, a};
    busyCycles = 0;
    starts     = 0;
    prevBusy   = bus.busy;
    for (int c = 0; c < window; c++) begin
      bus.KEY = (keySeq.size() > 0) ? keySeq.pop_front() : 4'hF;
      @(posedge clk);
      #1;
      if (bus.busy) busyCycles++;
      if (bus.busy && !prevBusy) starts++;
      prevBusy = bus.busy;
    end
    keySeq.delete();
  endtask

  function automatic int modelLatency(input logic [1:0] op, input logic [3:0] b);
    if (op == 2'd2 || (op == 2'd3 && b != 0)) return W;
    return 1;
  endfunction

  task automatic modelOp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib;
    ia = a;
    ib = b;
    mOp = op; mValid = 1'b1; mNeg = 1'b0; mErr = 1'b0;
    case (op)
      2'd0: mResult = 8'(ia + ib);
      2'd1: begin
        mResult = 8'((ia >= ib) ? ia - ib : ib - ia);
        mNeg    = (ia < ib);
      end
      2'd2: mResult = 8'(ia * ib);
      default: begin
        if (ib == 0) begin
          mResult = 8'd0;
          mErr    = 1'b1;
        end else begin
          mResult = {4'(ia % ib), 4'(ia / ib)};
        end
      end
    endcase
  endtask

  task automatic verifyOp(input string tag, input int expStarts, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b);
    if (expStarts == 1) modelOp(op, a, b);
    checkOutput({tag, ".starts"}, starts, expStarts);
    checkOutput({tag, ".busyCycles"}, busyCycles, (expStarts == 1) ? modelLatency(op, b) : 0);
    checkOutput({tag, ".busy"}, bus.busy, 1'b0);
    checkOutput({tag, ".valid"}, bus.valid, mValid);
    checkOutput({tag, ".result"}, bus.result, mResult);
    checkOutput({tag, ".op"}, bus.op, mOp);
    checkOutput({tag, ".neg"}, bus.neg, mNeg);
    checkOutput({tag, ".err"}, bus.err, mErr);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".result"}, bus.result, 8'd0);
    checkOutput({tag, ".op"}, bus.op, 2'd0);
    checkOutput({tag, ".busy"}, bus.busy, 1'b0);
    checkOutput({tag, ".valid"}, bus.valid, 1'b0);
    checkOutput({tag, ".neg"}, bus.neg, 1'b0);
    checkOutput({tag, ".err"}, bus.err, 1'b0);
  endtask

  initial begin
    logic [1:0] rop;
    logic [3:0] ra, rb;
    int         sawBusy;

    mResult = 0; mOp = 0; mValid = 0; mNeg = 0; mErr = 0;
    rst     = 1'b1;
    bus.KEY = 4'hF;
    bus.SW  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    applyStimulus(4'd0, 4'd0, 6);

    // ADD, including carry into bit 4
    pushKeys(4'b0001, 10); applyStimulus(4'd5, 4'd3, 30);   verifyOp("add1", 1, 2'd0, 4'd5, 4'd3);
    pushKeys(4'b0001, 10); applyStimulus(4'd15, 4'd1, 30);  verifyOp("add2", 1, 2'd0, 4'd15, 4'd1);

    // SUB negative and equal operands
    pushKeys(4'b0010, 10); applyStimulus(4'd3, 4'd5, 30);   verifyOp("sub1", 1, 2'd1, 4'd3, 4'd5);
    pushKeys(4'b0010, 10); applyStimulus(4'd5, 4'd5, 30);   verifyOp("sub2", 1, 2'd1, 4'd5, 4'd5);

    // MUL 15*15 with an ADD press landing while busy
    pushKeys(4'b0100, 2); pushKeys(4'b0101, 8);
    applyStimulus(4'd15, 4'd15, 30);                        verifyOp("mul", 1, 2'd2, 4'd15, 4'd15);

    // DIV and divide by zero
    pushKeys(4'b1000, 10); applyStimulus(4'd9, 4'd3, 30);   verifyOp("div1", 1, 2'd3, 4'd9, 4'd3);
    pushKeys(4'b1000, 10); applyStimulus(4'd7, 4'd0, 30);   verifyOp("div0", 1, 2'd3, 4'd7, 4'd0);

    // Short glitch gives no event
    pushKeys(4'b0001, 2); applyStimulus(4'd1, 4'd1, 20);    verifyOp("glitch", 0, 2'd0, 4'd1, 4'd1);

    // Simultaneous ADD and DIV: ADD wins
    pushKeys(4'b1001, 10); applyStimulus(4'd6, 4'd2, 30);   verifyOp("prio", 1, 2'd0, 4'd6, 4'd2);

    // Bouncing SUB key gives exactly one event
    pushKeys(4'b0010, 3); pushKeys(4'b0000, 1); pushKeys(4'b0010, 6);
    applyStimulus(4'd9, 4'd2, 30);                          verifyOp("bounce", 1, 2'd1, 4'd9, 4'd2);

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 4'($urandom);
      rb  = (i == 5) ? 4'd0 : 4'($urandom);
      pushKeys(4'b0001 << rop, 8);
      applyStimulus(ra, rb, 30);
      verifyOp($sformatf("rand%0d", i), 1, rop, ra, rb);
    end

    // Reset during the second MUL EXEC cycle with KEY[2] held through it
    bus.SW  = {2'b00, 4'd6, 4'd7};
    bus.KEY = 4'b1011;
    sawBusy = 0;
    for (int c = 0; c < 20 && sawBusy == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy) sawBusy = 1;
    end
    checkOutput("rstmul.busyStart", sawBusy, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAllZero("rstmul.reset");
    mResult = 0; mOp = 0; mValid = 0; mNeg = 0; mErr = 0;
    pushKeys(4'b0100, 15); applyStimulus(4'd7, 4'd6, 15);   verifyOp("rstmul.held", 0, 2'd2, 4'd7, 4'd6);
    pushKeys(4'b0000, 10); pushKeys(4'b0100, 10);
    applyStimulus(4'd7, 4'd6, 40);                          verifyOp("rstmul.again", 1, 2'd2, 4'd7, 4'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Sequential controller for the 4-bit arithmetic calculator on the DE10-Lite board.
- Debounces the four KEY push-buttons and turns each press into a one-cycle operation request.
- Latches operands from SW, runs ADD/SUB in one cycle and MUL/DIV as WIDTH-cycle iterative shift-add / restoring-divide.
- Holds a registered result with status flags for the HEX display decoders.

Parameters:
- WIDTH, 4: operand width in bits. Result width is 2*WIDTH.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a key level change. Board build overrides this to 500000.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- SW  in  10  SW[3:0]=A, SW[7:4]=B, SW[9:8] unused
- KEY  in  4  active-low buttons: KEY[0]=ADD, KEY[1]=SUB, KEY[2]=MUL, KEY[3]=DIV
- result  out  8  registered result, see arithmetic rules
- op  out  2  opcode of the last latched operation: 0=ADD, 1=SUB, 2=MUL, 3=DIV
- busy  out  1  high while in EXEC
- valid  out  1  result corresponds to the last latched operation
- neg  out  1  SUB result is negative
- err  out  1  DIV by zero

Behaviour:
- Reset: one clk, synchronous, active-high (rst=1 at a rising edge).
  - result=0, op=0, busy=0, valid=0, neg=0, err=0.
  - FSM goes to IDLE; synchronizers and debounce counters clear; debounced key state = released.
  - arm=0.
- Reset mid-operation: the operation is abandoned with no partial result.
- Arm rule:
  - arm is set once all four debounced keys read released.
  - Press events are generated only while arm=1.
  - A key held through reset produces no event until it is released and pressed again.
- Input path, per key:
  - 2-flop synchronizer.
  - Debounce counter: the debounced level changes only after the raw level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce resets the count.
  - Press event = one-cycle pulse on the debounced released->pressed transition.
- Simultaneous events in the same cycle: fixed priority KEY[0] > KEY[1] > KEY[2] > KEY[3]. Lower-priority events are dropped.
- FSM states:
  - IDLE:
    - On an event: latch A=SW[3:0], B=SW[7:4], op; clear cycle count; set busy=1, valid=0; go to EXEC.
  - EXEC:
    - ADD/SUB take 1 cycle; MUL/DIV take exactly WIDTH cycles.
    - DIV with B=0 takes 1 cycle and sets err.
    - At the edge that ends EXEC: register result/neg/err, set valid=1, busy=0; go to DONE.
    - Events arriving during EXEC are dropped, not queued.
  - DONE:
    - Outputs hold.
    - A new event behaves as in IDLE: valid drops and busy rises the cycle after the event.
    - result, neg and err keep their old values until overwritten.
- Latency, from the edge that samples the event to the edge that sets valid:
  - 1 cycle for ADD/SUB and DIV-by-zero.
  - WIDTH cycles for MUL/DIV.
  - busy is high for exactly that many cycles.
- Arithmetic, all unsigned operands:
  - ADD: result = A+B zero-extended; carry appears in result[4]. Maximum 30.
  - SUB: result = |A-B| zero-extended; neg=1 iff A<B; A=B gives 0 with neg=0.
  - MUL: result = A*B via shift-add, one partial product per cycle. Maximum 225.
  - DIV: restoring division, one quotient bit per cycle, MSB first. result[3:0]=quotient, result[7:4]=remainder.
  - DIV with B=0: result=0, err=1.
  - neg and err are cleared for every op they do not apply to.

Test Plan:
- Setup for all scenarios: DEBOUNCE_CYCLES=4; reset; all keys released.
- ADD: A=5, B=3, KEY[0] low 10 cycles -> exactly one event; busy high 1 cycle; result=8, neg=0, valid=1, op=0. Then A=15, B=1 -> result=16 (bit4 set).
- SUB: A=3, B=5, KEY[1] -> result=2, neg=1, op=1. Then A=5, B=5 -> result=0, neg=0.
- MUL: A=15, B=15, KEY[2] -> busy high 4 cycles, then result=225, valid=1. Pressing KEY[0] during busy is ignored: op stays 2, no second result.
- DIV: A=9, B=3, KEY[3] -> after 4 cycles result=8'h03, err=0. Then A=7, B=0 -> after 1 cycle result=0, err=1, valid=1.
- Debounce and priority:
  - KEY[0] low for 2 cycles then high -> no event; valid unchanged.
  - KEY[0] and KEY[3] pressed in the same cycle -> ADD only.
  - Bouncing KEY[1] (low 3, high 1, low 6) -> exactly one SUB.
- Reset mid-MUL: rst during EXEC cycle 2 -> next cycle all outputs 0 and FSM in IDLE. KEY[2] held through reset -> no event; release then press -> MUL runs.
